// File: rtl/frame_capture_buffer_if.sv
// frame_capture_buffer_if: producer write port, readback port and status of the capture buffer
interface frame_capture_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              write_fin;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_count;
  logic [1:0]        err;
  modport master (
    output start, wr_en, wr_addr, wr_data, write_fin, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, done, wr_count, err
  );
  modport slave (
    input  start, wr_en, wr_addr, wr_data, write_fin, rd_en, rd_addr,
    output rd_data, rd_valid, busy, done, wr_count, err
  );
endinterface

// File: rtl/frame_capture_buffer.sv
// frame_capture_buffer: captures (address, data) frame writes, signals done after a settle delay, then serves readback
module frame_capture_buffer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 900,
  parameter int FIN_DELAY = 1,
  parameter bit CLEAR_EN  = 1'b1
) (
  input logic clk,
  input logic rstb,
  frame_capture_buffer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, CAPTURE, DELAY, DONE} state_t;
  localparam int DLY_W = $clog2(FIN_DELAY + 2);
  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] LIM = AW1'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state, nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_cnt;
  logic [DLY_W-1:0] dly_cnt;
  logic cap, go, wr_in, rd_in, wr_ok, rd_ok;
  assign cap = state == CAPTURE || state == DELAY;
  assign go = bus.start && (state == IDLE || state == DONE);
  assign wr_in = {1'b0, bus.wr_addr} < LIM;
  assign rd_in = {1'b0, bus.rd_addr} < LIM;
  assign wr_ok = cap && bus.wr_en && wr_in;
  assign rd_ok = state == DONE && bus.rd_en;
  assign bus.busy = state == CLEAR || cap;
  assign bus.done = state == DONE;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) nxt = CLEAR_EN ? CLEAR : CAPTURE;
      CLEAR:      if (clr_cnt == LAST) nxt = CAPTURE;
      CAPTURE:    if (bus.write_fin) nxt = FIN_DELAY == 0 ? DONE : DELAY;
      DELAY:      if (dly_cnt <= DLY_W'(1)) nxt = DONE;
      default:    nxt = IDLE;
    endcase
  end
  // Frame memory carries no reset; CLEAR and CAPTURE are its only writers
  always_ff @(posedge clk)
    if (state == CLEAR) mem[clr_cnt] <= '0;
    else if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.wr_count <= '0;
      bus.err      <= '0;
      clr_cnt      <= '0;
      dly_cnt      <= '0;
    end else begin
      bus.rd_valid <= rd_ok;
      if (rd_ok) bus.rd_data <= rd_in ? mem[bus.rd_addr] : '0;
      if (state == CLEAR) clr_cnt <= clr_cnt == LAST ? '0 : clr_cnt + 1'b1;
      if (state == CAPTURE && bus.write_fin) dly_cnt <= DLY_W'(FIN_DELAY);
      else if (state == DELAY) dly_cnt <= dly_cnt - 1'b1;
      if (go) begin
        bus.wr_count <= '0;
        bus.err      <= '0;
      end else begin
        if (wr_ok && !(&bus.wr_count)) bus.wr_count <= bus.wr_count + 1'b1;
        if ((cap && bus.wr_en && !wr_in) || (rd_ok && !rd_in)) bus.err[0] <= 1'b1;
        if (!cap && bus.wr_en) bus.err[1] <= 1'b1;
      end
    end
endmodule

// File: tb/tb_frame_capture_buffer.sv
// tb_frame_capture_buffer: directed and randomized frames against a frame-level reference model
module tb_frame_capture_buffer;
  localparam int DEPTH = 900;
  logic clk = 1'b0;
  logic rstb = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_mem [DEPTH];
  int m_cnt;
  logic [1:0] m_err;
  logic [31:0] m_rd;
  bit m_cap, m_done;

  frame_capture_buffer_if #(.DATA_W(32), .ADDR_W(10)) bus ();
  frame_capture_buffer_if #(.DATA_W(32), .ADDR_W(10)) bus0 ();
  frame_capture_buffer_if #(.DATA_W(32), .ADDR_W(10)) bus4 ();

  // The FIN_DELAY=0 and FIN_DELAY=4 instances see exactly the same stimulus as the main one
  assign bus0.start = bus.start;      assign bus4.start = bus.start;
  assign bus0.wr_en = bus.wr_en;      assign bus4.wr_en = bus.wr_en;
  assign bus0.wr_addr = bus.wr_addr;  assign bus4.wr_addr = bus.wr_addr;
  assign bus0.wr_data = bus.wr_data;  assign bus4.wr_data = bus.wr_data;
  assign bus0.write_fin = bus.write_fin; assign bus4.write_fin = bus.write_fin;
  assign bus0.rd_en = bus.rd_en;      assign bus4.rd_en = bus.rd_en;
  assign bus0.rd_addr = bus.rd_addr;  assign bus4.rd_addr = bus.rd_addr;

  frame_capture_buffer #(.DEPTH(DEPTH), .FIN_DELAY(1), .CLEAR_EN(1'b1)) dut (.clk(clk), .rstb(rstb), .bus(bus));
  frame_capture_buffer #(.DEPTH(DEPTH), .FIN_DELAY(0), .CLEAR_EN(1'b0)) dut0 (.clk(clk), .rstb(rstb), .bus(bus0));
  frame_capture_buffer #(.DEPTH(DEPTH), .FIN_DELAY(4), .CLEAR_EN(1'b1)) dut4 (.clk(clk), .rstb(rstb), .bus(bus4));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    bus.write_fin = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_err = 2'b00;
    m_rd = '0;
    m_cap = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic start_frame();
    repeat (5) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    foreach (m_mem[i]) m_mem[i] = '0;
    m_cnt = 0;
    m_err = 2'b00;
    m_cap = 1'b0;
    m_done = 1'b0;
    repeat (DEPTH) tick();
    m_cap = 1'b1;
    chk("busy_capture", bus.busy, 1);
    chk("done_capture", bus.done, 0);
    chk("count_start", bus.wr_count, 0);
    chk("err_start", bus.err, 0);
  endtask

  task automatic wr(int a, logic [31:0] d, bit fin, bit poke = 1'b0);
    bus.wr_en = 1'b1;
    bus.wr_addr = a[9:0];
    bus.wr_data = d;
    bus.write_fin = fin;
    bus.start = poke;
    bus.rd_en = poke;
    bus.rd_addr = 10'd5;
    tick();
    idle();
    if (m_cap) begin
      if (a < DEPTH) begin
        m_mem[a] = d;
        if (m_cnt < 2047) m_cnt++;
      end else m_err[0] = 1'b1;
    end else m_err[1] = 1'b1;
    if (poke) chk("rd_ignored", bus.rd_valid, 0);
    chk("wr_count", bus.wr_count, m_cnt);
    chk("wr_err", bus.err, m_err);
  endtask

  task automatic finish_frame();
    chk("done_early", bus.done, 0);
    tick();
    chk("done_rise", bus.done, 1);
    chk("busy_done", bus.busy, 0);
    m_cap = 1'b0;
    m_done = 1'b1;
  endtask

  task automatic rd(int a);
    bus.rd_en = 1'b1;
    bus.rd_addr = a[9:0];
    tick();
    bus.rd_en = 1'b0;
    if (m_done) begin
      m_rd = a < DEPTH ? m_mem[a] : 32'h0;
      if (a >= DEPTH) m_err[0] = 1'b1;
    end
    chk("rd_valid", bus.rd_valid, m_done);
    chk("rd_data", bus.rd_data, m_rd);
    chk("rd_err", bus.err, m_err);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_rd_data"}, bus.rd_data, 0);
    chk({tag, "_count"}, bus.wr_count, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_busy4"}, bus4.busy, 0);
    chk({tag, "_done4"}, bus4.done, 0);
  endtask

  initial begin
    idle();
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    model_reset();
    repeat (3) tick();
    chk_zero("reset");
    rstb = 1'b1;

    // Frame 1: fill every address, end-of-frame on the last write
    start_frame();
    for (int k = 0; k < DEPTH; k++) wr(k, 32'hA000_0000 + k, k == DEPTH - 1);
    finish_frame();
    rd(5);
    tick();
    chk("rd_valid_one", bus.rd_valid, 0);

    // Frame 2: single write; neighbours must read back cleared
    start_frame();
    wr(10, 32'h1234, 1'b1);
    finish_frame();
    rd(10);
    rd(11);
    tick();
    chk("rd_valid_b2b_end", bus.rd_valid, 0);

    // Frame 3: delay 0 / 1 / 4 timing and a write landing inside the delay window
    start_frame();
    wr(3, 32'hBEEF, 1'b1);
    chk("d0_done_now", bus0.done, 1);
    chk("d4_wait0", bus4.done, 0);
    finish_frame();
    chk("d4_wait1", bus4.done, 0);
    wr(7, 32'hCAFE, 1'b0);
    chk("d4_wait2", bus4.done, 0);
    chk("d4_count", bus4.wr_count, 2);
    tick();
    chk("d4_wait3", bus4.done, 0);
    tick();
    chk("d4_done", bus4.done, 1);
    rd(3);
    chk("d0_rd_beef", bus0.rd_data, 32'hBEEF);
    chk("d4_rd_beef", bus4.rd_data, 32'hBEEF);
    rd(7);
    chk("d4_rd_cafe", bus4.rd_data, 32'hCAFE);
    idle();

    // Frame 4: randomized writes with out-of-range hits, ignored start/rd_en, then random readback
    start_frame();
    wr(900, 32'h1111_1111, 1'b0);
    wr(1023, 32'h2222_2222, 1'b0);
    for (int i = 0; i < 300; i++) begin
      int a;
      a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(900, 1023)) : int'($urandom_range(0, 899));
      wr(a, $urandom, i == 299, i == 50 || i == 51);
    end
    chk("err_oob", bus.err, 2'b01);
    finish_frame();
    wr(20, 32'hDEAD_0000, 1'b0);
    rd(20);
    rd(950);
    for (int i = 0; i < 40; i++) rd(int'($urandom_range(0, 1023)));
    tick();
    chk("rd_valid_idle", bus.rd_valid, 0);

    // Abort during CLEAR, then prove the following clear spans exactly DEPTH cycles
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (100) tick();
    rstb = 1'b0;
    #1;
    chk_zero("abort_clear");
    tick();
    rstb = 1'b1;
    model_reset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (DEPTH - 1) tick();
    bus.wr_en = 1'b1;
    bus.wr_addr = 10'd0;
    bus.wr_data = 32'h55;
    tick();
    chk("clear_last_drop_cnt", bus.wr_count, 0);
    chk("clear_last_drop_err", bus.err, 2'b10);
    chk("clear_last_busy", bus.busy, 1);
    tick();
    idle();
    chk("capture_first_cnt", bus.wr_count, 1);
    foreach (m_mem[i]) m_mem[i] = '0;
    m_mem[0] = 32'h55;
    m_cnt = 1;
    m_err = 2'b10;
    m_cap = 1'b1;

    // Abort during DELAY: no done may follow
    wr(899, $urandom, 1'b1);
    chk("delay_pending", bus.done, 0);
    rstb = 1'b0;
    #1;
    chk_zero("abort_delay");
    tick();
    rstb = 1'b1;
    repeat (6) tick();
    chk("no_done", bus.done, 0);
    chk("no_done4", bus4.done, 0);
    chk("idle_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_capture_buffer.md
Name: frame_capture_buffer

Overview:
- Synthesizable, parametrised capture buffer for the convolution output stream: stores (address, data) writes from the output-write stage into an internal frame memory.
- Detects end-of-frame from the producer's finish strobe, applies a configurable settle delay, then raises done and exposes a registered readback port.
- Sits after the convolution or output-ROM writer; replaces bench-only capture arrays so capture and readback also exist in silicon.

Parameters:
DATA_W, 32, width of captured data word
ADDR_W, 10, width of write/read address
DEPTH, 900, number of valid entries; legal addresses are 0..DEPTH-1; DEPTH <= 2^ADDR_W
FIN_DELAY, 1, cycles between accepted write_fin and done; 0 allowed
CLEAR_EN, 1, 1 = zero the whole memory after start before capture; 0 = skip clear

Ports:
clk  in  1  clock, all state on rising edge
rstb  in  1  asynchronous active-low reset
start  in  1  pulse; arms a new capture (honoured in IDLE and DONE only)
wr_en  in  1  write strobe from producer
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
write_fin  in  1  producer end-of-frame pulse
rd_en  in  1  readback request (honoured in DONE only)
rd_addr  in  ADDR_W  readback address
rd_data  out  DATA_W  readback data, registered
rd_valid  out  1  rd_data valid, one cycle per accepted rd_en
busy  out  1  high in CLEAR, CAPTURE, DELAY
done  out  1  high in DONE
wr_count  out  ADDR_W+1  accepted writes this frame, saturating at all-ones
err  out  2  sticky; bit0 = out-of-range address seen, bit1 = write dropped outside CAPTURE/DELAY

Behaviour:
- Reset (asynchronous, rstb low): state = IDLE; rd_data = 0, rd_valid = 0, busy = 0, done = 0, wr_count = 0, err = 0, clear/delay counters = 0. Memory array is not reset; its contents are undefined until a CLEAR or write.
- Reset mid-operation aborts any state immediately. No partial done is issued.
- States:
  - IDLE: start -> CLEAR if CLEAR_EN, else CAPTURE. On that start, wr_count and err clear to 0.
  - CLEAR: writes 0 to addresses 0..DEPTH-1, one per cycle, so it takes exactly DEPTH cycles, then -> CAPTURE. wr_en here is dropped and sets err[1]. write_fin is ignored.
  - CAPTURE: wr_en with wr_addr < DEPTH writes mem[wr_addr] = wr_data next edge and increments wr_count. wr_addr >= DEPTH drops the write, sets err[0], no increment. write_fin -> DELAY (loads counter with FIN_DELAY), or -> DONE directly if FIN_DELAY = 0. A write in the same cycle as write_fin is accepted.
  - DELAY: still accepts writes with the CAPTURE rules. Counts down one per cycle; -> DONE when the counter reaches 1. So done rises exactly FIN_DELAY cycles after the write_fin edge. Further write_fin is ignored.
  - DONE: done = 1. wr_en is dropped and sets err[1]. start -> CLEAR/CAPTURE as in IDLE, clearing wr_count and err.
- start in CLEAR, CAPTURE or DELAY is ignored.
- Readback, accepted only in DONE:
  - rd_en with rd_addr < DEPTH: rd_data = mem[rd_addr] and rd_valid = 1 on the next edge (1-cycle latency).
  - rd_addr >= DEPTH: rd_data = 0, rd_valid = 1, err[0] set.
  - rd_en outside DONE: ignored; rd_valid = 0; rd_data holds its last value.
- rd_valid is high only for the cycle after each accepted rd_en. Back-to-back reads are supported, one per cycle.
- Duplicate writes to the same address are last-write-wins. Each accepted write counts in wr_count.
- Memory is single-write, single-read; writes and reads are never concurrent because of the state gating.

Test Plan:
1. Reset, start (CLEAR_EN=1), write addr k with data 32'hA000_0000+k for k=0..899, pulse write_fin on the last write -> done rises 1 cycle later (FIN_DELAY=1), wr_count=900, err=0. Reading addr 5 gives rd_data=32'hA000_0005 with rd_valid one cycle after rd_en.
2. Second frame writes only addr 10 = 32'h1234 -> after done, addr 10 reads 32'h1234, addr 11 reads 0 (cleared), wr_count=1.
3. FIN_DELAY=0, write_fin in the same cycle as the write to addr 3 = 32'hBEEF -> done high the next cycle, addr 3 reads 32'hBEEF. FIN_DELAY=4 -> done exactly 4 cycles after the write_fin edge, and a write 2 cycles after write_fin is captured.
4. Write to addr 900 and 1023 during CAPTURE -> err=2'b01, wr_count unchanged. wr_en while in DONE -> err bit1 set, memory unchanged. rd_addr=950 in DONE -> rd_data=0, rd_valid=1.
5. Drop rstb low mid-CLEAR and mid-DELAY -> all outputs return to 0 at once, state IDLE, no done. A following start runs a full DEPTH-cycle clear (busy high for exactly 900 cycles before CAPTURE).
6. start pulsed during CAPTURE and rd_en during CAPTURE -> both ignored, wr_count keeps counting, rd_valid stays 0.
